// File: rtl/audio_pkg.sv
// Shared widths, limits and the PCM saturation helper for the audio output stage.
package audio_pkg;
    localparam int MIX_W      = 19;
    localparam int PCM_W      = 16;
    localparam int PCM_MAX    = 32767;
    localparam int PCM_MIN    = -32768;
    localparam int STABLE_WIN = 4;
    localparam int OPL_W      = 16;
    localparam int TANDY_W    = 11;
    localparam int CAP_W      = OPL_W + TANDY_W + 1;
    localparam int DCB_W      = 24;
    localparam int DCB_POLE   = 8;

    localparam logic signed [DCB_W-1:0] SAT_HI = DCB_W'(PCM_MAX);
    localparam logic signed [DCB_W-1:0] SAT_LO = DCB_W'(PCM_MIN);

    typedef struct packed {
        logic                    clip;
        logic signed [PCM_W-1:0] val;
    } sat_t;

    function automatic sat_t sat_pcm(input logic signed [DCB_W-1:0] x);
        sat_t r;
        r.clip = 1'b1;
        if (x > SAT_HI) begin
            r.val = PCM_W'(PCM_MAX);
        end else if (x < SAT_LO) begin
            r.val = PCM_W'(PCM_MIN);
        end else begin
            r.clip = 1'b0;
            r.val  = x[PCM_W-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/audio_out_stage_sd_dac1.sv
// First-order sigma-delta modulator: signed PCM in, one-bit density stream out.
module sd_dac1
    import audio_pkg::*;
(
    input  logic             clk_vga,
    input  logic             reset_wire,
    input  logic [PCM_W-1:0] pcm,
    output logic             dac_bit
);
    logic [PCM_W:0]   acc;
    logic [PCM_W-1:0] u;

    // Offset binary so that full negative scale maps to a zero-density stream.
    assign u = pcm ^ {1'b1, {(PCM_W-1){1'b0}}};

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[PCM_W-1:0]} + {1'b0, u};
        end
    end

    assign dac_bit = acc[PCM_W];
endmodule

// File: rtl/audio_out_stage.sv
// Audio output stage: stability-checked capture, mix, clamp, PCM strobe and sigma-delta bit.
// Define SND_DCBLOCK_EN to insert a one-pole DC blocker between clamp and output.
module audio_out_stage
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV  = 600,
    parameter int OPL_SHIFT   = 1,
    parameter int TANDY_SHIFT = 6,
    parameter int SPK_SHIFT   = 13
) (
    input  logic                clk_vga,
    input  logic                reset_wire,
    input  logic [OPL_W-1:0]    opl_in,
    input  logic [TANDY_W-1:0]  tandy_in,
    input  logic                speaker_in,
    input  logic                mute,
    output logic [PCM_W-1:0]    pcm_out,
    output logic                pcm_strobe,
    output logic                clip,
    output logic                dac_bit
);
    localparam int CNT_W = 12;
    localparam int WIN_W = $clog2(STABLE_WIN);

    logic [CNT_W-1:0] cnt;
    logic             strb;
    assign strb = (cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire)  cnt <= '0;
        else if (strb)   cnt <= '0;
        else             cnt <= cnt + 1'b1;
    end

    logic [CAP_W-1:0] cap_a, cap_b, held;
    logic [WIN_W-1:0] wcnt;
    logic             pending, cap_v, stable;
    assign stable = (cap_a == cap_b);

    // A capture that never settles still emits a sample, re-using the last held value.
    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            cap_a   <= '0;
            cap_b   <= '0;
            held    <= '0;
            wcnt    <= '0;
            pending <= 1'b0;
            cap_v   <= 1'b0;
        end else begin
            cap_a <= {opl_in, tandy_in, speaker_in};
            cap_b <= cap_a;
            cap_v <= 1'b0;
            if (strb) begin
                if (stable) begin
                    held    <= cap_b;
                    cap_v   <= 1'b1;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                    wcnt    <= '0;
                end
            end else if (pending) begin
                if (stable) begin
                    held    <= cap_b;
                    cap_v   <= 1'b1;
                    pending <= 1'b0;
                end else if (wcnt == WIN_W'(STABLE_WIN - 1)) begin
                    cap_v   <= 1'b1;
                    pending <= 1'b0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    logic signed [MIX_W-1:0] opl_t, tandy_t, spk_t, mix_c, sum_r;
    logic                    sum_v;
    sat_t                    sat_mix;

    assign opl_t   = {{(MIX_W-OPL_W){held[CAP_W-1]}}, held[CAP_W-1 -: OPL_W]} <<< OPL_SHIFT;
    assign tandy_t = {{(MIX_W-TANDY_W){1'b0}}, held[TANDY_W:1]} << TANDY_SHIFT;
    assign spk_t   = {{(MIX_W-1){1'b0}}, held[0]} << SPK_SHIFT;
    assign mix_c   = opl_t + tandy_t + spk_t;
    assign sat_mix = sat_pcm({{(DCB_W-MIX_W){sum_r[MIX_W-1]}}, sum_r});

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            sum_r <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_v <= cap_v;
            if (cap_v) sum_r <= mix_c;
        end
    end

`ifdef SND_DCBLOCK_EN
    logic signed [PCM_W-1:0] clamp_r;
    logic                    clamp_clip, clamp_v;
    logic signed [DCB_W-1:0] clamp_x, x_prev, y_prev, y_c;
    sat_t                    sat_dc;

    assign clamp_x = {{(DCB_W-PCM_W){clamp_r[PCM_W-1]}}, clamp_r};
    assign y_c     = clamp_x - x_prev + y_prev - (y_prev >>> DCB_POLE);
    assign sat_dc  = sat_pcm(y_c);

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            clamp_r    <= '0;
            clamp_clip <= 1'b0;
            clamp_v    <= 1'b0;
            x_prev     <= '0;
            y_prev     <= '0;
            pcm_out    <= '0;
            pcm_strobe <= 1'b0;
            clip       <= 1'b0;
        end else begin
            clamp_v    <= sum_v;
            pcm_strobe <= clamp_v;
            clip       <= 1'b0;
            if (sum_v) begin
                clamp_r    <= sat_mix.val;
                clamp_clip <= sat_mix.clip;
            end
            if (clamp_v) begin
                x_prev  <= clamp_x;
                y_prev  <= {{(DCB_W-PCM_W){sat_dc.val[PCM_W-1]}}, sat_dc.val};
                pcm_out <= mute ? '0 : sat_dc.val;
                clip    <= (clamp_clip | sat_dc.clip) & ~mute;
            end
        end
    end
`else
    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            pcm_out    <= '0;
            pcm_strobe <= 1'b0;
            clip       <= 1'b0;
        end else begin
            pcm_strobe <= sum_v;
            clip       <= 1'b0;
            if (sum_v) begin
                pcm_out <= mute ? '0 : sat_mix.val;
                clip    <= sat_mix.clip & ~mute;
            end
        end
    end
`endif

    sd_dac1 u_sd_dac1 (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .pcm        (pcm_out),
        .dac_bit    (dac_bit)
    );
endmodule

// File: tb/tb_audio_out_stage.sv
// Self-checking bench for audio_out_stage: directed vectors, corner sequences and random stimulus
// against a cycle-indexed reference model built from the input history.
module tb_audio_out_stage;
    localparam int DIV = 16;
    localparam int HM  = 8191;
`ifdef SND_DCBLOCK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk_vga = 1'b0;
    logic        reset_wire = 1'b1;
    logic [15:0] opl_in = '0;
    logic [10:0] tandy_in = '0;
    logic        speaker_in = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_strobe, clip, dac_bit;

    always #5 clk_vga = ~clk_vga;

    audio_out_stage #(.SAMPLE_DIV(DIV)) dut (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .opl_in     (opl_in),
        .tandy_in   (tandy_in),
        .speaker_in (speaker_in),
        .mute       (mute),
        .pcm_out    (pcm_out),
        .pcm_strobe (pcm_strobe),
        .clip       (clip),
        .dac_bit    (dac_bit)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 50) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model: expected sample events derived from the recorded input history.
    typedef struct {int t; int mix;} exp_t;
    exp_t        q[$];
    logic [27:0] ihist[8192];
    logic        mhist[8192];
    int          open_t = -1;
    logic [27:0] prev_held = '0;
    int          last_pcm = 0;
    int          xp = 0, yp = 0;

    function automatic int mix_of(input logic [27:0] v);
        int o;
        o = $signed(v[27:12]);
        return o * 2 + int'(v[11:1]) * 64 + int'(v[0]) * 8192;
    endfunction

    function automatic int clamp16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    always begin
        @(posedge clk_vga);
        #1;
        if (reset_wire) begin
            check("rst_pcm", int'($signed(pcm_out)), 0);
            check("rst_strobe", int'(pcm_strobe), 0);
            check("rst_clip", int'(clip), 0);
            check("rst_dac", int'(dac_bit), 0);
            cyc = 0; open_t = -1; q.delete();
            prev_held = '0; last_pcm = 0; xp = 0; yp = 0;
        end else begin
            cyc++;
            ihist[(cyc-1) & HM] = {opl_in, tandy_in, speaker_in};
            mhist[(cyc-1) & HM] = mute;
            if (cyc % DIV == DIV - 1) open_t = cyc;
            if (open_t >= 0) begin
                if (ihist[(cyc-1) & HM] == ihist[(cyc-2) & HM]) begin
                    prev_held = ihist[(cyc-2) & HM];
                    q.push_back('{cyc + LAT, mix_of(prev_held)});
                    open_t = -1;
                end else if (cyc - open_t == 4) begin
                    q.push_back('{cyc + LAT, mix_of(prev_held)});
                    open_t = -1;
                end
            end
            if (q.size() > 0 && q[0].t == cyc) begin
                exp_t e;
                int s, v, ep, ec;
                bit cl;
                e  = q.pop_front();
                s  = clamp16(e.mix);
                cl = (s != e.mix);
                v  = s;
`ifdef SND_DCBLOCK_EN
                begin
                    int y;
                    y = s - xp + yp - (yp >>> 8);
                    v = clamp16(y);
                    cl = cl | (v != y);
                    xp = s;
                    yp = v;
                end
`endif
                ep = mhist[(cyc-1) & HM] ? 0 : v;
                ec = mhist[(cyc-1) & HM] ? 0 : int'(cl);
                last_pcm = ep;
                check("strobe", int'(pcm_strobe), 1);
                check("pcm", int'($signed(pcm_out)), ep);
                check("clip", int'(clip), ec);
            end else begin
                check("no_strobe", int'(pcm_strobe), 0);
                check("clip_idle", int'(clip), 0);
                check("pcm_hold", int'($signed(pcm_out)), last_pcm);
            end
        end
    end

    task automatic wait_strobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_vga);
            if (pcm_strobe) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("strobe_timeout");
    endtask

    task automatic wait_phase(input int r);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk_vga);
            if (cyc % DIV == r) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("phase_timeout");
    endtask

    task automatic duty(input string name, input int exp);
        int ones;
        ones = 0;
        repeat (1024) begin
            @(negedge clk_vga);
            ones += int'(dac_bit);
        end
        tests++;
        if (ones < exp - 1 || ones > exp + 1) begin
            fails++;
            $display("FAIL %s: got %0d ones in 1024, expected %0d +/-1", name, ones, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] o, input logic [10:0] t, input logic s);
        opl_in = o; tandy_in = t; speaker_in = s;
    endtask

    typedef struct {
        logic [15:0] opl;
        logic [10:0] tandy;
        logic        spk;
        logic        mt;
        int          pcm;
        int          clp;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int at, t0, burst;
        tbl[0] = '{16'h4000, 11'd0,    1'b1, 1'b0,  32767, 1};
        tbl[1] = '{16'hC000, 11'd0,    1'b0, 1'b0, -32768, 0};
        tbl[2] = '{16'h8000, 11'd0,    1'b0, 1'b0, -32768, 1};
        tbl[3] = '{16'h0100, 11'd2,    1'b0, 1'b0,    640, 0};
        tbl[4] = '{16'h0000, 11'h7FF,  1'b1, 1'b0,  32767, 1};
        tbl[5] = '{16'h0000, 11'd100,  1'b0, 1'b0,   6400, 0};
        tbl[6] = '{16'hFFFF, 11'd0,    1'b0, 1'b0,     -2, 0};
        tbl[7] = '{16'h1000, 11'd0,    1'b0, 1'b1,      0, 0};
        tbl[8] = '{16'h4000, 11'd0,    1'b1, 1'b1,      0, 0};
        tbl[9] = '{16'h1000, 11'd0,    1'b0, 1'b0,   8192, 0};

        repeat (4) @(negedge clk_vga);
        set_in(16'h0000, 11'd0, 1'b0);
        reset_wire = 1'b0;

        // Silence after reset: first strobe timing and 50% density.
        wait_strobe(3 * DIV, at);
        check("first_strobe_cycle", at, DIV - 1 + LAT);
        check("first_pcm", int'($signed(pcm_out)), 0);
        duty("duty_zero", 512);

        foreach (tbl[i]) begin
            wait_strobe(2 * DIV, at);
            set_in(tbl[i].opl, tbl[i].tandy, tbl[i].spk);
            mute = tbl[i].mt;
            wait_strobe(2 * DIV, at);
`ifndef SND_DCBLOCK_EN
            check($sformatf("vec%0d_pcm", i), int'($signed(pcm_out)), tbl[i].pcm);
            check($sformatf("vec%0d_clip", i), int'(clip), tbl[i].clp);
`endif
        end

        // Mute gives mid-scale density; release restores the mix.
        wait_strobe(2 * DIV, at);
        mute = 1'b1;
        wait_strobe(2 * DIV, at);
        wait_strobe(2 * DIV, at);
        check("mute_pcm", int'($signed(pcm_out)), 0);
        repeat (4) @(negedge clk_vga);
        duty("duty_mute", 512);
        wait_strobe(2 * DIV, at);
        mute = 1'b0;
        wait_strobe(2 * DIV, at);
`ifndef SND_DCBLOCK_EN
        check("unmute_pcm", int'($signed(pcm_out)), 8192);
        repeat (4) @(negedge clk_vga);
        duty("duty_8192", 640);
`endif

        // Inputs unstable across the strobe for three checks, then settle.
        wait_phase(DIV - 3);
        t0 = cyc + 2;
        set_in(16'h0111, 11'd0, 1'b0);
        @(negedge clk_vga); set_in(16'h0222, 11'd0, 1'b0);
        @(negedge clk_vga); set_in(16'h0333, 11'd0, 1'b0);
        @(negedge clk_vga); set_in(16'h0010, 11'd0, 1'b0);
        wait_strobe(3 * DIV, at);
        check("late_strobe_delay", at - t0, LAT + 3);
`ifndef SND_DCBLOCK_EN
        check("late_pcm", int'($signed(pcm_out)), 32);
`endif

        // Never settles within the window: previous held value is repeated.
        wait_phase(DIV - 3);
        t0 = cyc + 2;
        for (int i = 0; i < 7; i++) begin
            set_in((i % 2 == 1) ? 16'h2000 : 16'h1000, 11'd0, 1'b0);
            @(negedge clk_vga);
        end
        set_in(16'h3000, 11'd0, 1'b0);
        wait_strobe(3 * DIV, at);
        check("giveup_delay", at - t0, LAT + 4);
`ifndef SND_DCBLOCK_EN
        check("giveup_pcm", int'($signed(pcm_out)), 32);
`endif
        wait_strobe(2 * DIV, at);
`ifndef SND_DCBLOCK_EN
        check("after_giveup_pcm", int'($signed(pcm_out)), 24576);
`endif

        // Reset while a sample is in flight.
        wait_phase(DIV - 1);
        @(negedge clk_vga);
        reset_wire = 1'b1;
        #1;
        check("midrst_pcm", int'($signed(pcm_out)), 0);
        check("midrst_strobe", int'(pcm_strobe), 0);
        check("midrst_dac", int'(dac_bit), 0);
        repeat (2) @(negedge clk_vga);
        reset_wire = 1'b0;
        wait_strobe(3 * DIV, at);
        check("post_rst_strobe_cycle", at, DIV - 1 + LAT);
`ifndef SND_DCBLOCK_EN
        check("post_rst_pcm", int'($signed(pcm_out)), 24576);
`endif

        // Random stimulus with bursts of instability and occasional mute toggles.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_vga);
            if (burst > 0) begin
                burst--;
                set_in(16'($urandom), 11'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 63) == 0) begin
                burst = $urandom_range(2, 9);
            end else if ($urandom_range(0, 7) == 0) begin
                set_in(16'($urandom), 11'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 299) == 0) mute = ~mute;
        end
        mute = 1'b0;
        repeat (3 * DIV) @(negedge clk_vga);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
